// File: rtl/trg_pkg.sv
// Shared constants for the trigger path: register map, command codes, run-state
// encoding and busy-vector bit positions (the monitor decodes the same vector).
package trg_pkg;

   localparam logic [7:0] ADDR_STATUS  = 8'h00;
   localparam logic [7:0] ADDR_CMD     = 8'h02;
   localparam logic [7:0] ADDR_CFG     = 8'h03;
   localparam logic [7:0] ADDR_FIX_DT  = 8'h04;
   localparam logic [7:0] ADDR_PAST_DT = 8'h05;
   localparam logic [7:0] ADDR_MAX_OUT = 8'h06;
   localparam logic [7:0] ADDR_OUTST   = 8'h07;
   localparam logic [7:0] ADDR_TRG_ID  = 8'h08;

   localparam logic [15:0] CMD_START   = 16'h0001;
   localparam logic [15:0] CMD_STOP    = 16'h0002;
   localparam logic [15:0] CMD_CLR_ERR = 16'h0004;
   localparam logic [15:0] RD_UNMAPPED = 16'hF001;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   // Bits 7:6 of the busy vector are reserved and read as zero.
   localparam int BSY_EXT   = 0;
   localparam int BSY_FIX   = 1;
   localparam int BSY_PAST  = 2;
   localparam int BSY_RDO   = 3;
   localparam int BSY_SEND  = 4;
   localparam int BSY_FORCE = 5;

   typedef logic [7:0] bsy_vec_t;

endpackage

// File: rtl/trg_dt_cnt.sv
// Loadable dead-time down-counter; busy while the count is nonzero.
module trg_dt_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         busy
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           cnt <= '0;
      else if (load)        cnt <= val;
      else if (cnt != '0)   cnt <= cnt - W'(1);
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/trg_ctrl.sv
// Trigger acceptance controller: registers requests, ORs the busy sources and
// tracks outstanding events. Optional trigger-id counter under TRG_CTRL_TRGID_EN.
module trg_ctrl
   import trg_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int OUT_W = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        reg_we_i,
   input  logic [7:0]  reg_addr_i,
   input  logic [15:0] reg_data_i,
   output logic [15:0] reg_data_o,
   input  logic        trg_req_i,
   input  logic        bsy_ext_i,
   input  logic        send_full_i,
   input  logic        rdo_done_i,
   output logic        trg_req_o,
   output logic        trg_acc_o,
   output logic        bsy_o,
   output logic        bsy_ext_o,
   output logic        bsy_fix_o,
   output logic        bsy_past_o,
   output logic        bsy_rdo_o,
   output logic        bsy_send_o,
`ifdef TRG_CTRL_TRGID_EN
   output logic [15:0] trg_id_o,
`endif
   output logic        bsy_force_o
);

   state_t           state, state_nxt;
   logic             req_q, ext_q, send_q, rdo_q, cfg_force, err_q, underflow;
   logic [CNT_W-1:0] fix_dt, past_dt;
   logic [OUT_W-1:0] max_out, max_out_nxt, outst, outst_nxt;
   bsy_vec_t         bsy_vec;

   logic cmd_wr, cmd_start, cmd_stop, cmd_clr;
   assign cmd_wr    = reg_we_i && (reg_addr_i == ADDR_CMD);
   assign cmd_start = cmd_wr && (reg_data_i == CMD_START);
   assign cmd_stop  = cmd_wr && (reg_data_i == CMD_STOP);
   assign cmd_clr   = cmd_wr && (reg_data_i == CMD_CLR_ERR);

   assign trg_req_o   = req_q && (state == ST_RUN);
   assign bsy_ext_o   = ext_q;
   assign bsy_send_o  = send_q;
   assign bsy_rdo_o   = rdo_q;
   assign bsy_force_o = cfg_force;
   assign bsy_o       = bsy_ext_o | bsy_fix_o | bsy_past_o | bsy_rdo_o | bsy_send_o | bsy_force_o;
   assign trg_acc_o   = trg_req_o && !bsy_o;

   trg_dt_cnt #(.W(CNT_W)) u_fix (
      .clk(clk_i), .rst_n(rst_ni), .load(trg_acc_o), .val(fix_dt), .busy(bsy_fix_o)
   );

   // Past protection reloads on every request seen in RUN, accepted or not.
   trg_dt_cnt #(.W(CNT_W)) u_past (
      .clk(clk_i), .rst_n(rst_ni), .load(trg_req_o), .val(past_dt), .busy(bsy_past_o)
   );

   always_comb begin
      outst_nxt = outst;
      underflow = 1'b0;
      if (trg_acc_o && !rdo_done_i) begin
         if (outst != '1) outst_nxt = outst + OUT_W'(1);
      end else if (!trg_acc_o && rdo_done_i) begin
         if (outst == '0) underflow = 1'b1;
         else             outst_nxt = outst - OUT_W'(1);
      end
   end

   assign max_out_nxt = (reg_we_i && reg_addr_i == ADDR_MAX_OUT) ? reg_data_i[OUT_W-1:0] : max_out;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_OFF:      if (cmd_start) state_nxt = ST_RUN;
         ST_RUN:      if (cmd_stop)  state_nxt = ST_STOPPING;
         ST_STOPPING: if (cmd_start)              state_nxt = ST_RUN;
                      else if (outst_nxt == '0)   state_nxt = ST_OFF;
         default:     state_nxt = ST_OFF;
      endcase
   end

   // rdo busy is evaluated from next-cycle values so the flop matches the
   // current outstanding count and limit in the cycle it is used.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_OFF;
         req_q     <= 1'b0;
         ext_q     <= 1'b0;
         send_q    <= 1'b0;
         rdo_q     <= 1'b0;
         cfg_force <= 1'b0;
         err_q     <= 1'b0;
         fix_dt    <= '0;
         past_dt   <= '0;
         max_out   <= '0;
         outst     <= '0;
      end else begin
         state   <= state_nxt;
         req_q   <= trg_req_i;
         ext_q   <= bsy_ext_i;
         send_q  <= send_full_i;
         rdo_q   <= (outst_nxt >= max_out_nxt);
         outst   <= outst_nxt;
         max_out <= max_out_nxt;
         err_q   <= (err_q && !cmd_clr) || underflow;
         if (reg_we_i && reg_addr_i == ADDR_CFG)     cfg_force <= reg_data_i[0];
         if (reg_we_i && reg_addr_i == ADDR_FIX_DT)  fix_dt    <= reg_data_i[CNT_W-1:0];
         if (reg_we_i && reg_addr_i == ADDR_PAST_DT) past_dt   <= reg_data_i[CNT_W-1:0];
      end
   end

`ifdef TRG_CTRL_TRGID_EN
   logic [15:0] trg_id_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          trg_id_q <= '0;
      else if (state == ST_OFF && cmd_start) trg_id_q <= '0;
      else if (trg_acc_o)                   trg_id_q <= trg_id_q + 16'd1;
   end
   assign trg_id_o = trg_id_q;
`endif

   always_comb begin
      bsy_vec            = '0;
      bsy_vec[BSY_EXT]   = bsy_ext_o;
      bsy_vec[BSY_FIX]   = bsy_fix_o;
      bsy_vec[BSY_PAST]  = bsy_past_o;
      bsy_vec[BSY_RDO]   = bsy_rdo_o;
      bsy_vec[BSY_SEND]  = bsy_send_o;
      bsy_vec[BSY_FORCE] = bsy_force_o;
   end

   always_comb begin
      reg_data_o = RD_UNMAPPED;
      case (reg_addr_i)
         ADDR_STATUS:  reg_data_o = {state, err_q, 5'b0, bsy_vec};
         ADDR_CMD:     reg_data_o = 16'h0000;
         ADDR_CFG:     reg_data_o = {15'b0, cfg_force};
         ADDR_FIX_DT:  reg_data_o = 16'(fix_dt);
         ADDR_PAST_DT: reg_data_o = 16'(past_dt);
         ADDR_MAX_OUT: reg_data_o = 16'(max_out);
         ADDR_OUTST:   reg_data_o = 16'(outst);
`ifdef TRG_CTRL_TRGID_EN
         ADDR_TRG_ID:  reg_data_o = trg_id_q;
`endif
         default:      reg_data_o = RD_UNMAPPED;
      endcase
   end

endmodule

// File: tb/tb_trg_ctrl.sv
// Bench for trg_ctrl: register-map vector table, directed corner sequences,
// and a randomized run against an arithmetic reference model.
module tb_trg_ctrl;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        reg_we = 1'b0;
   logic [7:0]  reg_addr = '0;
   logic [15:0] reg_wdata = '0, reg_rdata;
   logic        trg_req = 1'b0, bsy_ext = 1'b0, send_full = 1'b0, rdo_done = 1'b0;
   logic        trg_req_q, trg_acc, bsy;
   logic        b_ext, b_fix, b_past, b_rdo, b_send, b_force;
`ifdef TRG_CTRL_TRGID_EN
   logic [15:0] trg_id;
`endif

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   trg_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n),
      .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_data_i(reg_wdata), .reg_data_o(reg_rdata),
      .trg_req_i(trg_req), .bsy_ext_i(bsy_ext), .send_full_i(send_full), .rdo_done_i(rdo_done),
      .trg_req_o(trg_req_q), .trg_acc_o(trg_acc), .bsy_o(bsy),
      .bsy_ext_o(b_ext), .bsy_fix_o(b_fix), .bsy_past_o(b_past),
      .bsy_rdo_o(b_rdo), .bsy_send_o(b_send),
`ifdef TRG_CTRL_TRGID_EN
      .trg_id_o(trg_id),
`endif
      .bsy_force_o(b_force)
   );

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      step();
      reg_we = 1'b0;
   endtask

   task automatic do_reset();
      trg_req = 0; bsy_ext = 0; send_full = 0; rdo_done = 0; reg_we = 0;
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic req_check(input string name, input logic exp_acc);
      trg_req = 1'b1; step(); trg_req = 1'b0;
      sample(); chk(name, trg_acc, exp_acc);
      step(); step();
   endtask

   int n, f_dt, p_dt, mo;
   int m_fix, m_past, m_out;
   logic m_req, m_ext, m_send, e_bsy, e_acc;

   initial begin
      // reset state while reset is held
      #3;
      reg_addr = 8'h00;
      #1;
      chk("rst_acc", trg_acc, 0);
      chk("rst_req", trg_req_q, 0);
      chk("rst_bsy", {b_ext, b_fix, b_past, b_rdo, b_send, b_force, bsy}, 0);
      chk("rst_status", reg_rdata, 16'h0000);
      do_reset();

      // register map table
      vt.push_back('{1'b0, 8'h40, 16'h0000, 16'hF001});
      vt.push_back('{1'b0, 8'h01, 16'h0000, 16'hF001});
`ifdef TRG_CTRL_TRGID_EN
      vt.push_back('{1'b0, 8'h08, 16'h0000, 16'h0000});
`else
      vt.push_back('{1'b0, 8'h08, 16'h0000, 16'hF001});
`endif
      vt.push_back('{1'b0, 8'h07, 16'h0000, 16'h0000});
      vt.push_back('{1'b1, 8'h04, 16'h1234, 16'h0000});
      vt.push_back('{1'b0, 8'h04, 16'h0000, 16'h1234});
      vt.push_back('{1'b1, 8'h05, 16'h00A5, 16'h0000});
      vt.push_back('{1'b0, 8'h05, 16'h0000, 16'h00A5});
      vt.push_back('{1'b1, 8'h06, 16'h01FF, 16'h0000});
      vt.push_back('{1'b0, 8'h06, 16'h0000, 16'h00FF});
      vt.push_back('{1'b0, 8'h00, 16'h0000, 16'h0000});
      vt.push_back('{1'b1, 8'h03, 16'h0003, 16'h0000});
      vt.push_back('{1'b0, 8'h03, 16'h0000, 16'h0001});
      vt.push_back('{1'b0, 8'h00, 16'h0000, 16'h0020});
      vt.push_back('{1'b1, 8'h03, 16'h0000, 16'h0000});
      vt.push_back('{1'b1, 8'h02, 16'h0008, 16'h0000});
      vt.push_back('{1'b0, 8'h00, 16'h0000, 16'h0000});
      vt.push_back('{1'b1, 8'h02, 16'h0002, 16'h0000});
      vt.push_back('{1'b0, 8'h00, 16'h0000, 16'h0000});
      vt.push_back('{1'b1, 8'h02, 16'h0001, 16'h0000});
      vt.push_back('{1'b0, 8'h00, 16'h0000, 16'h4000});
      vt.push_back('{1'b1, 8'h02, 16'h0002, 16'h0000});
      vt.push_back('{1'b0, 8'h00, 16'h0000, 16'h8000});
      vt.push_back('{1'b0, 8'h00, 16'h0000, 16'h0000});
      for (int i = 0; i < vt.size(); i++) begin
         reg_we = vt[i].we; reg_addr = vt[i].addr; reg_wdata = vt[i].data;
         sample();
         if (!vt[i].we) chk($sformatf("vec%0d", i), reg_rdata, vt[i].exp);
         step();
      end
      reg_we = 1'b0;

      // basic accept with fix dead time of 10
      do_reset();
      wr(8'h06, 16'h00FF); wr(8'h04, 16'd10); wr(8'h02, 16'h0001);
      trg_req = 1'b1; step(); trg_req = 1'b0;
      sample(); chk("first_acc", trg_acc, 1); chk("first_fix", b_fix, 0);
      step();
      n = 0;
      for (int i = 0; i < 14; i++) begin
         trg_req = (i == 2);
         sample();
         if (b_fix) n++;
         if (i == 3) begin chk("fix_rej_req", trg_req_q, 1); chk("fix_rej_acc", trg_acc, 0); end
         step();
      end
      trg_req = 1'b0;
      chk("fix_window", n, 10);
      req_check("fix_after", 1);

      // past protection: requests at 0,3,9
      do_reset();
      wr(8'h06, 16'h00FF); wr(8'h05, 16'd5); wr(8'h02, 16'h0001);
      for (int i = 0; i < 12; i++) begin
         trg_req = (i == 0 || i == 3 || i == 9);
         sample();
         if (i == 1)  chk("past_acc0", trg_acc, 1);
         if (i == 4)  chk("past_rej3", trg_acc, 0);
         if (i == 9)  chk("past_busy9", b_past, 1);
         if (i == 10) chk("past_acc9", trg_acc, 1);
         step();
      end
      trg_req = 1'b0;

      // outstanding limit
      do_reset();
      wr(8'h06, 16'd2); wr(8'h02, 16'h0001);
      req_check("out_acc1", 1);
      req_check("out_acc2", 1);
      trg_req = 1'b1; step(); trg_req = 1'b0;
      sample(); chk("out_rej3", trg_acc, 0); chk("out_rdo", b_rdo, 1);
      step();
      rdo_done = 1'b1; step(); rdo_done = 1'b0;
      reg_addr = 8'h07; sample(); chk("out_after_done", reg_rdata, 1);
      step();
      req_check("out_acc4", 1);
      wr(8'h06, 16'd3);
      trg_req = 1'b1; step(); trg_req = 1'b0; rdo_done = 1'b1;
      sample(); chk("sim_acc", trg_acc, 1);
      step(); rdo_done = 1'b0;
      reg_addr = 8'h07; sample(); chk("sim_count", reg_rdata, 2);
      step();

      // stop and drain
      wr(8'h02, 16'h0002);
      reg_addr = 8'h00; sample(); chk("stopping", reg_rdata[15:14], 2);
      trg_req = 1'b1; step(); trg_req = 1'b0;
      sample(); chk("stop_req_ign", trg_req_q, 0); chk("stop_acc", trg_acc, 0);
      step();
      rdo_done = 1'b1; step(); step(); rdo_done = 1'b0;
      reg_addr = 8'h00; sample(); chk("drained_off", reg_rdata[15:14], 0);
      step();
      reg_addr = 8'h07; sample(); chk("drained_out", reg_rdata, 0);
      rdo_done = 1'b1; step(); rdo_done = 1'b0;
      reg_addr = 8'h00; sample(); chk("underflow_err", reg_rdata[13], 1);
      step();
      wr(8'h02, 16'h0004);
      reg_addr = 8'h00; sample(); chk("clr_err", reg_rdata[13], 0);
      step();

      // force / ext / send
      do_reset();
      wr(8'h06, 16'h00FF); wr(8'h02, 16'h0001);
      wr(8'h03, 16'h0001);
      reg_addr = 8'h00; sample(); chk("force_bit", b_force, 1); chk("force_stat", reg_rdata[5], 1);
      step();
      req_check("force_rej", 0);
      wr(8'h03, 16'h0000);
      bsy_ext = 1'b1; reg_addr = 8'h00;
      sample(); chk("ext_lat0", b_ext, 0);
      step();
      sample(); chk("ext_bit", b_ext, 1); chk("ext_stat", reg_rdata[0], 1);
      step();
      req_check("ext_rej", 0);
      bsy_ext = 1'b0; step(); step();
      send_full = 1'b1;
      sample(); chk("send_lat0", b_send, 0);
      step();
      sample(); chk("send_bit", b_send, 1); chk("send_stat", reg_rdata[4], 1);
      step();
      req_check("send_rej", 0);
      send_full = 1'b0; step(); step();
      req_check("clear_acc", 1);

      // randomized run against the reference model
      do_reset();
      f_dt = $urandom_range(0, 6); p_dt = $urandom_range(0, 4); mo = $urandom_range(1, 4);
      wr(8'h06, 16'(mo)); wr(8'h04, 16'(f_dt)); wr(8'h05, 16'(p_dt)); wr(8'h02, 16'h0001);
      m_req = 0; m_ext = 0; m_send = 0; m_fix = 0; m_past = 0; m_out = 0;
      for (int c = 0; c < 600; c++) begin
         trg_req   = ($urandom_range(0, 99) < 30);
         bsy_ext   = ($urandom_range(0, 99) < 8);
         send_full = ($urandom_range(0, 99) < 8);
         rdo_done  = ($urandom_range(0, 99) < 20);
         reg_addr  = 8'h07;
         sample();
         e_bsy = m_ext || m_send || (m_fix > 0) || (m_past > 0) || (m_out >= mo);
         e_acc = m_req && !e_bsy;
         chk("rnd_acc", trg_acc, e_acc);
         chk("rnd_bsy", bsy, e_bsy);
         chk("rnd_out", reg_rdata, m_out);
         m_fix  = e_acc ? f_dt : (m_fix > 0 ? m_fix - 1 : 0);
         m_past = m_req ? p_dt : (m_past > 0 ? m_past - 1 : 0);
         if (e_acc && !rdo_done)              m_out = (m_out < 255) ? m_out + 1 : 255;
         else if (!e_acc && rdo_done && m_out > 0) m_out = m_out - 1;
         m_req = trg_req; m_ext = bsy_ext; m_send = send_full;
         step();
      end
      trg_req = 0; bsy_ext = 0; send_full = 0; rdo_done = 0;

      // async reset in the middle of dead time
      do_reset();
      wr(8'h06, 16'h00FF); wr(8'h04, 16'd10); wr(8'h05, 16'd10); wr(8'h02, 16'h0001);
      req_check("ar_acc", 1);
      sample(); chk("ar_fix_busy", b_fix, 1);
      step();
      rst_n = 1'b0; reg_addr = 8'h00;
      #1;
      chk("ar_outs", {trg_acc, trg_req_q, bsy, b_fix, b_past, b_rdo}, 0);
      chk("ar_status", reg_rdata, 16'h0000);
      reg_addr = 8'h40;
      #1;
      chk("ar_unmapped", reg_rdata, 16'hF001);
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
